// File: rtl/parking_gate_ctrl_if.sv
// Sensor-in / occupancy-out bundle of the parking entrance controller.
// master: sensor side driving beams and observing occupancy (bench, debouncers).
// slave : the occupancy controller itself.
interface parking_gate_ctrl_if #(
   parameter int CNT_W = 4
);
   logic             sensor_a;
   logic             sensor_b;
   logic             car_in;
   logic             car_out;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             error;
   logic             overflow;

   modport master (
      output sensor_a, sensor_b,
      input  car_in, car_out, count, full, empty, error, overflow
   );

   modport slave (
      input  sensor_a, sensor_b,
      output car_in, car_out, count, full, empty, error, overflow
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking lot entrance occupancy controller.
// Decodes the four-phase beam crossing {a,b}: 00->10->11->01->00 is an entry,
// 00->01->11->10->00 is an exit, and keeps a saturating occupancy count.
// Optional feature macro: PARKING_TIMEOUT_EN adds a stall watchdog that forces
// ERR when a sequence state is held unchanged for TIMEOUT cycles.
module parking_gate_ctrl #(
   parameter int CAPACITY = 15,
   parameter int CNT_W    = 4,
   parameter int TIMEOUT  = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   parking_gate_ctrl_if.slave  bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_IN1  = 3'd1;
   localparam logic [2:0] S_IN2  = 3'd2;
   localparam logic [2:0] S_IN3  = 3'd3;
   localparam logic [2:0] S_OUT1 = 3'd4;
   localparam logic [2:0] S_OUT2 = 3'd5;
   localparam logic [2:0] S_OUT3 = 3'd6;
   localparam logic [2:0] S_ERR  = 3'd7;

   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

   logic [2:0]       state;
   logic [2:0]       nxt;
   logic [1:0]       ab;
   logic             entry_evt;
   logic             exit_evt;
   logic [CNT_W-1:0] count;

   assign ab = {bus.sensor_a, bus.sensor_b};

`ifdef PARKING_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT + 1);

   logic [STALL_W-1:0] stall_cnt;
   logic [1:0]         ab_prev;
   logic               in_seq;
   logic               stall_hit;

   assign in_seq    = (state != S_IDLE) && (state != S_ERR);
   assign stall_hit = in_seq && (stall_cnt == STALL_W'(TIMEOUT));

   // Stall watchdog: restarts on any beam change or outside a sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         ab_prev   <= 2'b00;
      end else begin
         ab_prev <= ab;
         if (!in_seq || (ab != ab_prev))
            stall_cnt <= '0;
         else
            stall_cnt <= stall_cnt + STALL_W'(1);
      end
   end
`else
   // Watchdog not built; parameter kept for a uniform instantiation interface.
   localparam int TIMEOUT_UNUSED = TIMEOUT;
`endif

   // Next-state decode of the crossing sequence and event detection.
   always_comb begin
      nxt       = state;
      entry_evt = 1'b0;
      exit_evt  = 1'b0;
      case (state)
         S_IDLE: case (ab)
            2'b10:   nxt = S_IN1;
            2'b01:   nxt = S_OUT1;
            2'b11:   nxt = S_ERR;
            default: nxt = S_IDLE;
         endcase
         S_IN1: case (ab)
            2'b11:   nxt = S_IN2;
            2'b00:   nxt = S_IDLE;
            2'b01:   nxt = S_ERR;
            default: nxt = S_IN1;
         endcase
         S_IN2: case (ab)
            2'b01:   nxt = S_IN3;
            2'b10:   nxt = S_IN1;
            2'b00:   nxt = S_ERR;
            default: nxt = S_IN2;
         endcase
         S_IN3: case (ab)
            2'b00: begin
               nxt       = S_IDLE;
               entry_evt = 1'b1;
            end
            2'b11:   nxt = S_IN2;
            2'b10:   nxt = S_ERR;
            default: nxt = S_IN3;
         endcase
         S_OUT1: case (ab)
            2'b11:   nxt = S_OUT2;
            2'b00:   nxt = S_IDLE;
            2'b10:   nxt = S_ERR;
            default: nxt = S_OUT1;
         endcase
         S_OUT2: case (ab)
            2'b10:   nxt = S_OUT3;
            2'b01:   nxt = S_OUT1;
            2'b00:   nxt = S_ERR;
            default: nxt = S_OUT2;
         endcase
         S_OUT3: case (ab)
            2'b00: begin
               nxt      = S_IDLE;
               exit_evt = 1'b1;
            end
            2'b11:   nxt = S_OUT2;
            2'b01:   nxt = S_ERR;
            default: nxt = S_OUT3;
         endcase
         default: nxt = (ab == 2'b00) ? S_IDLE : S_ERR;
      endcase
`ifdef PARKING_TIMEOUT_EN
      // A stalled sequence is abandoned; the watchdog overrides any event.
      if (stall_hit) begin
         nxt       = S_ERR;
         entry_evt = 1'b0;
         exit_evt  = 1'b0;
      end
`endif
   end

   // State, event pulses, saturating occupancy count and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         count        <= '0;
         bus.car_in   <= 1'b0;
         bus.car_out  <= 1'b0;
         bus.error    <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         state       <= nxt;
         bus.car_in  <= entry_evt;
         bus.car_out <= exit_evt;
         bus.error   <= (nxt == S_ERR);
         if (entry_evt) begin
            if (count < CAP) count        <= count + CNT_W'(1);
            else             bus.overflow <= 1'b1;
         end else if (exit_evt) begin
            if (count != '0) count        <= count - CNT_W'(1);
            else             bus.overflow <= 1'b1;
         end
      end
   end

   assign bus.count = count;
   assign bus.full  = (count == CAP);
   assign bus.empty = (count == '0);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: entry/exit sequences, saturation,
// illegal sequences, aborts, mid-sequence reset and (with PARKING_TIMEOUT_EN)
// the stall watchdog.
module tb_parking_gate_ctrl;

   localparam int CAPACITY = 15;
   localparam int CNT_W    = 4;
   localparam int TIMEOUT  = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_in   = 0;
   int   n_out  = 0;
   int   in_base;
   int   out_base;

   parking_gate_ctrl_if #(.CNT_W(CNT_W)) ifc ();

   parking_gate_ctrl #(
      .CAPACITY (CAPACITY),
      .CNT_W    (CNT_W),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   // Count event pulses in mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (ifc.car_in)  n_in  <= n_in + 1;
      if (ifc.car_out) n_out <= n_out + 1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Present {a,b} for n cycles; returns 1 time unit after the last sampling edge.
   task automatic drive(input logic [1:0] v, input int n);
      @(negedge clk);
      ifc.sensor_a = v[1];
      ifc.sensor_b = v[0];
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      ifc.sensor_a = 1'b0;
      ifc.sensor_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      ifc.sensor_a = 1'b0;
      ifc.sensor_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_count",    int'(ifc.count),    0);
      check_eq("rst_empty",    int'(ifc.empty),    1);
      check_eq("rst_full",     int'(ifc.full),     0);
      check_eq("rst_error",    int'(ifc.error),    0);
      check_eq("rst_overflow", int'(ifc.overflow), 0);
      check_eq("rst_car_in",   int'(ifc.car_in),   0);
      check_eq("rst_car_out",  int'(ifc.car_out),  0);
      @(negedge clk);
      rst = 1'b0;

      // Slow entry, each phase held 3 cycles.
      in_base = n_in;
      drive(2'b00, 3);
      drive(2'b10, 3);
      drive(2'b11, 3);
      drive(2'b01, 3);
      check_eq("entry_no_early_pulse", int'(ifc.car_in), 0);
      drive(2'b00, 1);
      check_eq("entry_pulse", int'(ifc.car_in), 1);
      check_eq("entry_count", int'(ifc.count),  1);
      check_eq("entry_empty", int'(ifc.empty),  0);
      drive(2'b00, 1);
      check_eq("entry_pulse_width", int'(ifc.car_in), 0);
      check_eq("entry_pulses", n_in - in_base, 1);

      // Fast exit.
      out_base = n_out;
      drive(2'b01, 1);
      drive(2'b11, 1);
      drive(2'b10, 1);
      drive(2'b00, 1);
      check_eq("exit_pulse",    int'(ifc.car_out),  1);
      check_eq("exit_count",    int'(ifc.count),    0);
      check_eq("exit_empty",    int'(ifc.empty),    1);
      check_eq("exit_overflow", int'(ifc.overflow), 0);
      drive(2'b00, 1);
      check_eq("exit_pulses", n_out - out_base, 1);

      // 16 back-to-back entries saturate at CAPACITY.
      in_base = n_in;
      for (int i = 1; i <= 16; i++) begin
         drive(2'b10, 1);
         drive(2'b11, 1);
         drive(2'b01, 1);
         drive(2'b00, 1);
         if (i == 14) check_eq("full_before_cap", int'(ifc.full), 0);
         if (i == 15) begin
            check_eq("full_at_cap",     int'(ifc.full),     1);
            check_eq("count_at_cap",    int'(ifc.count),    15);
            check_eq("overflow_at_cap", int'(ifc.overflow), 0);
         end
      end
      check_eq("sat_pulse",    int'(ifc.car_in),   1);
      check_eq("sat_count",    int'(ifc.count),    15);
      check_eq("sat_overflow", int'(ifc.overflow), 1);
      drive(2'b00, 1);
      check_eq("sat_pulses", n_in - in_base, 16);

      // Illegal 10 -> 01 jump, held through 11, cleared by 00.
      in_base  = n_in;
      out_base = n_out;
      drive(2'b10, 1);
      check_eq("ill_no_err_yet", int'(ifc.error), 0);
      drive(2'b01, 1);
      check_eq("ill_err_set", int'(ifc.error), 1);
      drive(2'b11, 2);
      check_eq("ill_err_hold", int'(ifc.error), 1);
      drive(2'b00, 1);
      check_eq("ill_err_clear", int'(ifc.error), 0);
      check_eq("ill_count",     int'(ifc.count), 15);
      drive(2'b00, 1);
      check_eq("ill_no_in",  n_in - in_base, 0);
      check_eq("ill_no_out", n_out - out_base, 0);

      // Reset clears count and sticky overflow.
      apply_reset();
      check_eq("rst2_count",    int'(ifc.count),    0);
      check_eq("rst2_overflow", int'(ifc.overflow), 0);

      // Abort, then a backing-up entry.
      in_base = n_in;
      drive(2'b10, 2);
      drive(2'b00, 2);
      check_eq("abort_no_event", n_in - in_base, 0);
      check_eq("abort_error",    int'(ifc.error), 0);
      drive(2'b10, 1);
      drive(2'b11, 1);
      drive(2'b10, 1);
      drive(2'b11, 1);
      drive(2'b01, 1);
      drive(2'b00, 1);
      check_eq("back_pulse", int'(ifc.car_in), 1);
      drive(2'b00, 1);
      check_eq("back_pulses", n_in - in_base, 1);
      check_eq("back_count",  int'(ifc.count), 1);

      // Reset in the middle of an exit sequence.
      out_base = n_out;
      drive(2'b01, 1);
      drive(2'b11, 1);
      @(negedge clk);
      rst = 1'b1;
      ifc.sensor_a = 1'b0;
      ifc.sensor_b = 1'b0;
      @(posedge clk);
      #1;
      check_eq("midrst_count",   int'(ifc.count),    0);
      check_eq("midrst_empty",   int'(ifc.empty),    1);
      check_eq("midrst_full",    int'(ifc.full),     0);
      check_eq("midrst_error",   int'(ifc.error),    0);
      check_eq("midrst_car_out", int'(ifc.car_out),  0);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b00, 2);
      check_eq("midrst_no_exit", n_out - out_base, 0);

`ifdef PARKING_TIMEOUT_EN
      // Hold 11 in IN2; the watchdog must fire after TIMEOUT cycles.
      drive(2'b10, 1);
      drive(2'b11, 10);
      check_eq("to_early", int'(ifc.error), 0);
      drive(2'b11, 15);
      check_eq("to_fired", int'(ifc.error), 1);
      drive(2'b00, 1);
      check_eq("to_clear", int'(ifc.error), 0);
      check_eq("to_count", int'(ifc.count), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end, observed 0, expected 1");
      $fatal(1);
   end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Occupancy controller for the parking lot entrance. It consumes two debounced beam sensors: `sensor_a` on the outside and `sensor_b` on the inside. It decodes the four-phase crossing sequence into car-entered and car-exited events and maintains the occupancy count with full/empty flags. Illegal or stalled sequences are flagged as errors. It sits directly downstream of the per-sensor debouncers and drives the display/gate logic.

## Interface
- `CAPACITY`, default 15: maximum occupancy; count saturates here.
- `CNT_W`, default 4: width of `count`; must satisfy 2^CNT_W > CAPACITY.
- `TIMEOUT`, default 50_000_000: stall limit in clk cycles (used only with `PARKING_TIMEOUT_EN`).
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `sensor_a`  in  1  debounced outer beam; 1 = blocked.
- `sensor_b`  in  1  debounced inner beam; 1 = blocked.
- `car_in`  out  1  one-cycle pulse per completed entry.
- `car_out`  out  1  one-cycle pulse per completed exit.
- `count`  out  CNT_W  current occupancy.
- `full`  out  1  `count == CAPACITY`.
- `empty`  out  1  `count == 0`.
- `error`  out  1  high while the FSM is in ERR.
- `overflow`  out  1  sticky; set by an entry while full or an exit while empty; cleared only by `rst`.

## Operation
- The sensor pair {a,b} is sampled each cycle.
- States: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR.
- IDLE:
  - 10 → IN1; 01 → OUT1; 11 → ERR; 00 → stay.
- IN1 (expects 10):
  - 11 → IN2; 00 → IDLE (abort, no event); 01 → ERR.
- IN2 (expects 11):
  - 01 → IN3; 10 → IN1 (car backing out); 00 → ERR.
- IN3 (expects 01):
  - 00 → IDLE with entry event; 11 → IN2; 10 → ERR.
- OUT1/OUT2/OUT3 mirror IN1/IN2/IN3 with a and b swapped. The OUT3 → IDLE transition on 00 produces an exit event.
- ERR: stays in ERR until {a,b} = 00, then → IDLE. No events are produced.
- Entry event:
  - `car_in` = 1 for one cycle.
  - If `count < CAPACITY`, count increments; otherwise count holds and `overflow` sets.
- Exit event:
  - `car_out` = 1 for one cycle.
  - If `count > 0`, count decrements; otherwise count holds and `overflow` sets.
- Only one sequence is tracked at a time. Entry and exit events can never occur in the same cycle.
- `full`/`empty` are combinational from `count`.
- Reset values: state IDLE, `count` 0, `car_in` 0, `car_out` 0, `error` 0, `overflow` 0. Therefore `empty` = 1 and `full` = 0.

## Timing
- The state register, `count`, `car_in`, `car_out` and `overflow` all update on the same posedge.
- The event pulse and the count change appear one cycle after the final 00 sample is present at the input, i.e. visible in the cycle following that posedge.
- `error` is registered: it asserts in the cycle after the illegal sample and deasserts in the cycle after the first 00 sample.
- Minimum legal crossing is 4 cycles (one per phase). Phases may dwell for any number of cycles.
- `rst` mid-sequence: abandons the sequence with no event and forces all reset values at that posedge. `rst` has priority over every other condition.
- Back-to-back crossings: IDLE may be left on the cycle immediately after an event. A pulse is never longer than one cycle.

## Configuration
- `PARKING_TIMEOUT_EN` defined:
  - A stall counter resets on every sensor change and in IDLE/ERR, and otherwise increments in IN1–3/OUT1–3.
  - When the counter reaches `TIMEOUT`, the FSM → ERR, even if the inputs are still legal.
  - The counter width is `$clog2(TIMEOUT+1)`.
- `PARKING_TIMEOUT_EN` undefined: no stall counter is built, and sequence states may be held indefinitely.

## Test plan
- Reset, then 00→10→11→01→00 with each phase held 3 cycles → one `car_in` pulse, `count` = 1, `empty` = 0.
- From `count` = 1: 00→01→11→10→00 → one `car_out` pulse, `count` = 0, `empty` = 1, `overflow` = 0.
- 16 full entries with CAPACITY = 15 → `full` = 1 after the 15th. The 16th gives a `car_in` pulse, `count` stays 15, `overflow` = 1.
- Illegal jump 10→01 → `error` = 1 the next cycle; 11 holds ERR; 00 → `error` = 0, no events, `count` unchanged.
- Aborted and backing sequences 10→00 and 10→11→10→11→01→00 → no event for the first; exactly one `car_in` for the second.
- With `PARKING_TIMEOUT_EN` and TIMEOUT = 20: hold 11 in IN2 for 25 cycles → `error` rises after 20 cycles. Also assert `rst` mid-sequence and check all outputs return to reset values.
